// File: rtl/mem_lsu_pkg.sv
// Shared load/store opcode codes, FSM state type and opcode decode helpers
// for the mem_lsu MEM stage.
package mem_lsu_pkg;

    localparam int unsigned LSOP_W = 4;

    localparam logic [LSOP_W-1:0] LSOP_NONE = 4'd0;
    localparam logic [LSOP_W-1:0] LSOP_LB   = 4'd1;
    localparam logic [LSOP_W-1:0] LSOP_LH   = 4'd2;
    localparam logic [LSOP_W-1:0] LSOP_LW   = 4'd3;
    localparam logic [LSOP_W-1:0] LSOP_LBU  = 4'd4;
    localparam logic [LSOP_W-1:0] LSOP_LHU  = 4'd5;
    localparam logic [LSOP_W-1:0] LSOP_SB   = 4'd6;
    localparam logic [LSOP_W-1:0] LSOP_SH   = 4'd7;
    localparam logic [LSOP_W-1:0] LSOP_SW   = 4'd8;

    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST,
        ST_DONE
    } lsu_state_e;

    function automatic logic is_load(input logic [LSOP_W-1:0] op);
        return (op == LSOP_LB) || (op == LSOP_LH) || (op == LSOP_LW) ||
               (op == LSOP_LBU) || (op == LSOP_LHU);
    endfunction

    function automatic logic is_store(input logic [LSOP_W-1:0] op);
        return (op == LSOP_SB) || (op == LSOP_SH) || (op == LSOP_SW);
    endfunction

    // Unknown codes report 0 bytes and are treated like LSOP_NONE.
    function automatic logic [2:0] op_bytes(input logic [LSOP_W-1:0] op);
        logic [2:0] n;
        case (op)
            LSOP_LB, LSOP_LBU, LSOP_SB: n = 3'd1;
            LSOP_LH, LSOP_LHU, LSOP_SH: n = 3'd2;
            LSOP_LW, LSOP_SW:           n = 3'd4;
            default:                    n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// Load result extension: turns the byte assembly register into the
// sign/zero-extended 32-bit writeback value for the given load opcode.
module lsu_load_ext
    import mem_lsu_pkg::*;
(
    input  logic [31:0]       raw,
    input  logic [LSOP_W-1:0] lsop,
    output logic [31:0]       result
);

    always_comb begin
        result = '0;
        case (lsop)
            LSOP_LB:  result = {{24{raw[7]}}, raw[7:0]};
            LSOP_LBU: result = {24'd0, raw[7:0]};
            LSOP_LH:  result = {{16{raw[15]}}, raw[15:0]};
            LSOP_LHU: result = {16'd0, raw[15:0]};
            LSOP_LW:  result = raw;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: ALU results pass straight to MEM/WB; loads/stores run byte-serially
// over a granted 8-bit RAM port. Optional feature macro: MEM_MISALIGN_CHK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [LSOP_W-1:0] mem_lsop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_sdata_i,
    output logic [4:0]        wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              stallreq_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    input  logic              ram_gnt_i
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    lsu_state_e        state, state_nxt;
    logic [1:0]        k, k_nxt;
    logic [DATA_W-1:0] asm_q;
    logic              cap_pend;
    logic [1:0]        cap_lane;
    logic              load_op, store_op, mem_op, last_byte;
    logic              misaligned, mis_done;
    logic [2:0]        nbytes;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] sdata_sh;

    assign load_op   = is_load(mem_lsop_i);
    assign store_op  = is_store(mem_lsop_i);
    assign mem_op    = load_op || store_op;
    assign nbytes    = op_bytes(mem_lsop_i);
    assign last_byte = ({1'b0, k} == (nbytes - 3'd1));
    assign sdata_sh  = mem_sdata_i >> {k, 3'b000};

    assign ram_a_o    = mem_addr_i + ADDR_W'(k);
    assign ram_dout_o = sdata_sh[7:0];

`ifdef MEM_MISALIGN_CHK_EN
    logic mis_q;

    assign misaligned = ((nbytes == 3'd2) && mem_addr_i[0]) ||
                        ((nbytes == 3'd4) && (mem_addr_i[1:0] != 2'b00));
    assign mis_done   = mis_q;
    assign misalign_o = rst && (state == ST_DONE) && mis_q;

    // Set only on the IDLE->DONE shortcut, so it is live exactly in that DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state == ST_IDLE) && mem_op && misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign mis_done   = 1'b0;
`endif

    lsu_load_ext u_load_ext (
        .raw    (asm_q),
        .lsop   (mem_lsop_i),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            k        <= '0;
            asm_q    <= '0;
            cap_pend <= 1'b0;
            cap_lane <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            cap_pend <= (state == ST_XFER) && ram_gnt_i && load_op;
            cap_lane <= k;
            // Read data trails its grant by one cycle; the lane is remembered with it.
            if (state == ST_IDLE) begin
                asm_q <= '0;
            end else if (cap_pend) begin
                asm_q[{cap_lane, 3'b000} +: 8] <= ram_din_i;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        stallreq_o = 1'b0;
        ram_req_o  = 1'b0;
        ram_we_o   = 1'b0;
        wb_wd_o    = '0;
        wb_wreg_o  = WRITE_DISABLE;
        wb_wdata_o = '0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    stallreq_o = 1'b1;
                    k_nxt      = '0;
                    state_nxt  = misaligned ? ST_DONE : ST_XFER;
                end else begin
                    wb_wd_o    = mem_wd_i;
                    wb_wreg_o  = mem_wreg_i;
                    wb_wdata_o = mem_wdata_i;
                end
            end
            ST_XFER: begin
                stallreq_o = 1'b1;
                ram_req_o  = 1'b1;
                ram_we_o   = store_op;
                if (ram_gnt_i) begin
                    if (last_byte) begin
                        state_nxt = load_op ? ST_LAST : ST_DONE;
                    end else begin
                        k_nxt = k + 2'd1;
                    end
                end
            end
            ST_LAST: begin
                stallreq_o = 1'b1;
                state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                wb_wd_o    = mem_wd_i;
                wb_wreg_o  = (load_op && !mis_done) ? mem_wreg_i : WRITE_DISABLE;
                wb_wdata_o = mis_done ? '0 : ext_data;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Outputs are quiet while reset is held so an aborted access issues no request.
        if (!rst) begin
            stallreq_o = 1'b0;
            ram_req_o  = 1'b0;
            ram_we_o   = 1'b0;
            wb_wd_o    = '0;
            wb_wreg_o  = WRITE_DISABLE;
            wb_wdata_o = '0;
        end
    end

endmodule
